button_press_ctrl: RTL

//   Sits directly downstream of the per-button debouncer. Turns one clean, debounced button

---
 rtl/btn_pkg.sv | 19 +
 rtl/btn_timer.sv | 29 ++
 rtl/button_press_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared button-control definitions: state encoding and default timing constants.
package btn_pkg;

  localparam logic [1:0] BTN_IDLE   = 2'd0;
  localparam logic [1:0] BTN_PRESS  = 2'd1;
  localparam logic [1:0] BTN_REPEAT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = BTN_IDLE,
    ST_PRESS  = BTN_PRESS,
    ST_REPEAT = BTN_REPEAT
  } btn_state_e;

  // Default timing, also used by the alarm-clock control FSM.
  localparam int unsigned BTN_HOLD_CYC_DEF   = 1000;
  localparam int unsigned BTN_REPEAT_CYC_DEF = 200;
  localparam int unsigned BTN_CNT_W_DEF      = 16;

endpackage

// File: rtl/btn_timer.sv
// Hold/repeat counter: clears to zero, increments on request, flags terminal count
// against a runtime limit supplied by the controller.
module btn_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             tc_c
);

  logic [CNT_W-1:0] cnt;

  // Counter register; clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc_c = (cnt == limit);

endmodule

// File: rtl/button_press_ctrl.sv
// Button event generator: converts a debounced level into press, long-press and
// auto-repeat pulses. Define BTN_RELEASE_EN to add the rel_p release pulse;
// without it rel_p is tied low and no extra flop is built.
module button_press_ctrl
  import btn_pkg::*;
#(
  parameter int unsigned HOLD_CYC   = BTN_HOLD_CYC_DEF,
  parameter int unsigned REPEAT_CYC = BTN_REPEAT_CYC_DEF,
  parameter int unsigned CNT_W      = BTN_CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic d,
  output logic press_p,
  output logic long_p,
  output logic rep_p,
  output logic held,
  output logic rel_p
);

  btn_state_e       state;
  logic             d_q;
  logic             rise_c;
  logic             active_c;
  logic             tc_c;
  logic             tmr_inc_c;
  logic             tmr_clr_c;
  logic [CNT_W-1:0] limit_c;

  assign rise_c   = d & ~d_q & en;
  assign active_c = (state == ST_PRESS) || (state == ST_REPEAT);
  assign limit_c  = (state == ST_PRESS) ? CNT_W'(HOLD_CYC - 1) : CNT_W'(REPEAT_CYC - 1);

  // Count only while holding below threshold; any exit, threshold hit or idle clears.
  assign tmr_inc_c = en && active_c && d && !tc_c;
  assign tmr_clr_c = !tmr_inc_c;

  btn_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr_c),
    .inc   (tmr_inc_c),
    .limit (limit_c),
    .tc_c  (tc_c)
  );

  // Previous level; resets high so a button held through reset is not a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= 1'b1;
    end else begin
      d_q <= d;
    end
  end

  // Control FSM with registered pulse and held outputs; release beats threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      press_p <= 1'b0;
      long_p  <= 1'b0;
      rep_p   <= 1'b0;
      held    <= 1'b0;
    end else begin
      press_p <= 1'b0;
      long_p  <= 1'b0;
      rep_p   <= 1'b0;
      if (!en) begin
        state <= ST_IDLE;
        held  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rise_c) begin
              press_p <= 1'b1;
              state   <= ST_PRESS;
            end
          end
          ST_PRESS: begin
            if (!d) begin
              state <= ST_IDLE;
            end else if (tc_c) begin
              long_p <= 1'b1;
              held   <= 1'b1;
              state  <= ST_REPEAT;
            end
          end
          ST_REPEAT: begin
            if (!d) begin
              state <= ST_IDLE;
              held  <= 1'b0;
            end else if (tc_c) begin
              rep_p <= 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            held  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef BTN_RELEASE_EN
  // Release pulse when an active hold ends because the button was let go.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_p <= 1'b0;
    end else begin
      rel_p <= en && active_c && !d;
    end
  end
`else
  assign rel_p = 1'b0;
`endif

endmodule
